// File: rtl/id_seq_checker.sv
// Receive-side checker for the ID digit sequence: tracks progress through the
// configured BCD ID (forward or reversed), pulses match and keeps saturating counters.
`timescale 1ns/1ps
module id_seq_checker #(
    parameter int unsigned ID_LEN = 8,
    parameter logic [31:0] ID     = 32'h8765_4321
) (
    input  logic       clk100M,
    input  logic       sys_rst_n,
    input  logic       clr,
    input  logic       digit_vld,
    input  logic [3:0] digit_in,
    input  logic       U_D,
    output logic [3:0] idx,
    output logic       match,
    output logic [7:0] match_cnt,
    output logic       bad_bcd,
    output logic [7:0] err_cnt
);

    localparam int unsigned DIG_W = 4;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ID_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HIT   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_d;
    logic               match_d;
    logic [CNT_W-1:0]   match_cnt_d, err_cnt_d;
    logic               bad_bcd_d;
    logic               dir_q, dir_d;
    logic [IDX_W-1:0]   cur_idx_c;
    logic [DIG_W-1:0]   exp_cur_c, exp_first_c;

    // Digit expected at position i for the given direction.
    function automatic logic [DIG_W-1:0] exp_digit(input logic [IDX_W-1:0] i, input logic up);
        int unsigned k;
        logic [31:0] sh;
        k  = up ? 32'(i) : (ID_LEN - 1 - 32'(i));
        sh = ID >> (DIG_W * k);
        return sh[DIG_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

    // A direction change abandons the partial sequence without counting an error.
    assign cur_idx_c   = (U_D != dir_q) ? '0 : idx;
    assign exp_cur_c   = exp_digit(cur_idx_c, U_D);
    assign exp_first_c = exp_digit('0, U_D);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx;
        match_d     = 1'b0;
        match_cnt_d = match_cnt;
        err_cnt_d   = err_cnt;
        bad_bcd_d   = bad_bcd;
        dir_d       = dir_q;

        if (state_q == HIT) begin
            state_d = IDLE;
        end

        if (clr) begin
            state_d     = IDLE;
            idx_d       = '0;
            match_cnt_d = '0;
            err_cnt_d   = '0;
            bad_bcd_d   = 1'b0;
        end else if (digit_vld) begin
            dir_d = U_D;
            if (digit_in > DIG_W'(9)) begin
                bad_bcd_d = 1'b1;
                err_cnt_d = sat_inc(err_cnt);
                idx_d     = '0;
                state_d   = IDLE;
            end else if (digit_in == exp_cur_c) begin
                if (cur_idx_c == LAST_IDX) begin
                    match_d     = 1'b1;
                    match_cnt_d = sat_inc(match_cnt);
                    idx_d       = '0;
                    state_d     = HIT;
                end else begin
                    idx_d   = cur_idx_c + IDX_W'(1);
                    state_d = TRACK;
                end
            end else begin
                // Only first-digit overlap is recovered.
                err_cnt_d = sat_inc(err_cnt);
                if (digit_in == exp_first_c) begin
                    idx_d   = IDX_W'(1);
                    state_d = TRACK;
                end else begin
                    idx_d   = '0;
                    state_d = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk100M or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            idx       <= '0;
            match     <= 1'b0;
            match_cnt <= '0;
            err_cnt   <= '0;
            bad_bcd   <= 1'b0;
            dir_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            idx       <= idx_d;
            match     <= match_d;
            match_cnt <= match_cnt_d;
            err_cnt   <= err_cnt_d;
            bad_bcd   <= bad_bcd_d;
            dir_q     <= dir_d;
        end
    end

endmodule

// File: tb/tb_id_seq_checker.sv
// Bench for id_seq_checker: directed scenarios plus random digit streams checked
// through an expected-response queue against a sequence-level reference model.
`timescale 1ns/1ps
module tb_id_seq_checker;

    localparam int unsigned N   = 8;
    localparam logic [31:0] IDV = 32'h8765_4321;

    logic       clk100M = 1'b0;
    logic       sys_rst_n, clr, digit_vld, U_D;
    logic [3:0] digit_in;
    logic [3:0] idx;
    logic       match, bad_bcd;
    logic [7:0] match_cnt, err_cnt;

    always #5 clk100M = ~clk100M;

    id_seq_checker #(.ID_LEN(N), .ID(IDV)) dut (
        .clk100M(clk100M), .sys_rst_n(sys_rst_n), .clr(clr), .digit_vld(digit_vld),
        .digit_in(digit_in), .U_D(U_D), .idx(idx), .match(match),
        .match_cnt(match_cnt), .bad_bcd(bad_bcd), .err_cnt(err_cnt)
    );

    typedef struct packed {
        logic [3:0] idx;
        logic       match;
        logic [7:0] mcnt;
        logic       bad;
        logic [7:0] ecnt;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: progress through an explicit digit list per direction.
    int seq_up[N];
    int seq_dn[N];
    int prog, mcnt, ecnt;
    bit mdir, mbad, mmatch;

    function automatic void model_reset();
        prog = 0; mcnt = 0; ecnt = 0; mdir = 1'b1; mbad = 1'b0; mmatch = 1'b0;
    endfunction

    function automatic void model_step(input bit c, input bit v, input int d, input bit ud);
        int want;
        mmatch = 1'b0;
        if (c) begin
            prog = 0; mcnt = 0; ecnt = 0; mbad = 1'b0;
        end else if (v) begin
            if (ud != mdir) prog = 0;
            mdir = ud;
            want = ud ? seq_up[prog] : seq_dn[prog];
            if (d > 9) begin
                mbad = 1'b1; prog = 0;
                if (ecnt < 255) ecnt++;
            end else if (d == want) begin
                if (prog == N - 1) begin
                    mmatch = 1'b1; prog = 0;
                    if (mcnt < 255) mcnt++;
                end else begin
                    prog++;
                end
            end else begin
                if (ecnt < 255) ecnt++;
                prog = (d == (ud ? seq_up[0] : seq_dn[0])) ? 1 : 0;
            end
        end
    endfunction

    function automatic exp_t snap();
        exp_t e;
        e.idx = 4'(prog); e.match = mmatch; e.mcnt = 8'(mcnt); e.bad = mbad; e.ecnt = 8'(ecnt);
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs settle just after each rising edge; one expectation per edge.
    always @(posedge clk100M) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("idx",       int'(idx),       int'(e.idx));
            check("match",     int'(match),     int'(e.match));
            check("match_cnt", int'(match_cnt), int'(e.mcnt));
            check("bad_bcd",   int'(bad_bcd),   int'(e.bad));
            check("err_cnt",   int'(err_cnt),   int'(e.ecnt));
        end
    end

    task automatic cyc(input bit c, input bit v, input int d, input bit ud);
        @(negedge clk100M);
        clr = c; digit_vld = v; digit_in = 4'(d); U_D = ud;
        model_step(c, v, d, ud);
        q.push_back(snap());
    endtask

    task automatic feed(input int d, input bit ud);
        cyc(1'b0, 1'b1, d, ud);
    endtask

    task automatic feed_seq(input bit ud);
        for (int i = 0; i < N; i++) feed(ud ? seq_up[i] : seq_dn[i], ud);
    endtask

    // Asynchronous reset: outputs must clear before the next clock edge.
    task automatic do_reset();
        @(negedge clk100M);
        sys_rst_n = 1'b0; clr = 1'b0; digit_vld = 1'b0;
        model_reset();
        #1;
        check("rst_idx",       int'(idx),       0);
        check("rst_match",     int'(match),     0);
        check("rst_match_cnt", int'(match_cnt), 0);
        check("rst_bad_bcd",   int'(bad_bcd),   0);
        check("rst_err_cnt",   int'(err_cnt),   0);
        q.push_back(snap());
        @(negedge clk100M);
        sys_rst_n = 1'b1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, d, r;
        bit ud, c, v;
        logic [31:0] idw;
        idw = IDV;
        for (int i = 0; i < N; i++) seq_up[i] = int'((idw >> (4 * i)) & 32'hF);
        for (int i = 0; i < N; i++) seq_dn[i] = seq_up[N - 1 - i];

        sys_rst_n = 1'b0; clr = 1'b0; digit_vld = 1'b0; digit_in = '0; U_D = 1'b1;
        model_reset();
        repeat (2) @(negedge clk100M);
        sys_rst_n = 1'b1;
        do_reset();

        // Forward sequence, contiguous.
        feed_seq(1'b1);
        cyc(1'b0, 1'b0, 0, 1'b1);

        // Reversed sequence with 3-cycle gaps.
        for (int i = 0; i < N; i++) begin
            feed(seq_dn[i], 1'b0);
            repeat (3) cyc(1'b0, 1'b0, 0, 1'b0);
        end

        // First-digit recovery: 1,2,3,1 then the rest.
        do_reset();
        feed(1, 1'b1); feed(2, 1'b1); feed(3, 1'b1); feed(1, 1'b1);
        for (int i = 1; i < N; i++) feed(seq_up[i], 1'b1);

        // Invalid BCD at idx 5, then clear.
        for (int i = 0; i < 5; i++) feed(seq_up[i], 1'b1);
        feed(12, 1'b1);
        cyc(1'b1, 1'b1, seq_up[0], 1'b1);
        cyc(1'b0, 1'b0, 0, 1'b1);

        // Direction flip mid-sequence abandons progress without error.
        feed(1, 1'b1); feed(2, 1'b1); feed(3, 1'b1);
        feed_seq(1'b0);
        cyc(1'b0, 1'b0, 0, 1'b0);

        // Back-to-back sequences up to counter saturation, then reset at idx 4.
        cyc(1'b1, 1'b0, 0, 1'b1);
        for (int s = 0; s < 300; s++) feed_seq(1'b1);
        for (int i = 0; i < 4; i++) feed(seq_up[i], 1'b1);
        do_reset();

        // Random streams biased toward the expected next digit.
        ud = 1'b1;
        for (int k = 0; k < 2500; k++) begin
            r = int'($urandom_range(0, 99));
            c = (r < 2);
            v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) < 3) ud = ~ud;
            p = (ud != mdir) ? 0 : prog;
            r = int'($urandom_range(0, 99));
            if (r < 75)      d = ud ? seq_up[p] : seq_dn[p];
            else if (r < 85) d = int'($urandom_range(0, 15));
            else             d = int'($urandom_range(0, 9));
            cyc(c, v, d, ud);
        end
        cyc(1'b0, 1'b0, 0, ud);

        for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk100M);
        #2;
        if (q.size() > 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
